// File: rtl/any1_pkg.sv
// Shared types and constants for the any1 instruction fetch path.
package any1_pkg;

  localparam int AWID      = 32;
  localparam int LINE_BITS = 512;
  localparam int BEAT_BITS = 128;
  localparam int NBEATS    = LINE_BITS / BEAT_BITS;
  localparam int BIDX_W    = $clog2(NBEATS);
  // Byte-offset widths of a beat and of a line.
  localparam int BEAT_OFS  = $clog2(BEAT_BITS / 8);
  localparam int LINE_OFS  = $clog2(LINE_BITS / 8);

  // Line/ip record handed to the instruction aligner. ip and pip are
  // ip[AWID-1:-1]: vector bit 0 is the fractional bit ip[-1].
  typedef struct packed {
    logic                 v;
    logic [LINE_BITS-1:0] cacheline;
    logic [AWID:0]        ip;
    logic [AWID:0]        pip;
    logic                 predict_taken;
  } sInstAlignIn;

  typedef enum logic [1:0] {
    IFILL_IDLE,
    IFILL_BEAT,
    IFILL_DRAIN,
    IFILL_DONE
  } ifill_state_e;

  // Byte address of beat b inside the line whose line address is line_adr.
  function automatic logic [AWID-1:0] beat_addr(
    input logic [AWID-LINE_OFS-1:0] line_adr,
    input logic [BIDX_W-1:0]        b
  );
    return {line_adr, b, {BEAT_OFS{1'b0}}};
  endfunction

endpackage

// File: rtl/any1_bus_tmo.sv
// Bus acknowledge watchdog: counts wait cycles of a strobed beat and flags
// expiry on the TMO-th cycle without an acknowledge.
module any1_bus_tmo #(
  parameter int unsigned TMO = 255
) (
  input  logic rst_i,
  input  logic clk_i,
  input  logic load_i,    // new burst starts: restart from zero
  input  logic ack_i,     // beat acknowledged: restart from zero
  input  logic run_i,     // a beat is outstanding and unacknowledged this cycle
  output logic expire_o
);

  localparam int unsigned CW = (TMO < 2) ? 1 : $clog2(TMO + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of completed wait cycles, so the current cycle is number cnt_q+1.
  assign expire_o = run_i && (cnt_q == CW'(TMO - 1));

  // Next count: clear on load/ack, otherwise advance while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i || ack_i) begin
      cnt_d = '0;
    end else if (run_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/any1_iline_fill.sv
// Instruction cache line fill: on a fetch miss, reads the line as a wrapping
// critical-beat-first burst, assembles it and presents it to the aligner.
module any1_iline_fill
  import any1_pkg::*;
#(
  parameter int unsigned TMO = 255
) (
  input  logic                 rst_i,
  input  logic                 clk_i,
  input  logic                 miss_i,
  input  logic [AWID:0]        miss_ip_i,
  input  logic [AWID:0]        miss_pip_i,
  input  logic                 miss_pt_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic [AWID-1:0]      adr_o,
  input  logic                 ack_i,
  input  logic                 err_i,
  input  logic [BEAT_BITS-1:0] dat_i,
  output sInstAlignIn          o,
  output logic                 ferr_o
);

  ifill_state_e       state_q, state_d;
  logic [BIDX_W-1:0]  beat_q,  beat_d;   // slice index of the strobed beat
  logic [BIDX_W-1:0]  bcnt_q,  bcnt_d;   // beats acknowledged so far
  logic [AWID:0]      ip_q,    ip_d;
  logic [AWID:0]      pip_q,   pip_d;
  logic               pt_q,    pt_d;
  logic               cyc_q,   cyc_d;
  logic               stb_q,   stb_d;
  logic [AWID-1:0]    adr_q,   adr_d;
  logic               busy_q,  busy_d;
  logic               ferr_q,  ferr_d;
  sInstAlignIn        o_q,     o_d;

  logic               tmo_load;
  logic               tmo_run;
  logic               tmo_expire;

  // Watchdog runs whenever a strobed beat is waiting for its acknowledge.
  assign tmo_run = ((state_q == IFILL_BEAT) || (state_q == IFILL_DRAIN)) && !ack_i;

  any1_bus_tmo #(.TMO(TMO)) u_tmo (
    .rst_i    (rst_i),
    .clk_i    (clk_i),
    .load_i   (tmo_load),
    .ack_i    (ack_i),
    .run_i    (tmo_run),
    .expire_o (tmo_expire)
  );

  // Fill sequencing: next state and next value of every registered output.
  // NOTE: every signal is given its hold value first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    bcnt_d   = bcnt_q;
    ip_d     = ip_q;
    pip_d    = pip_q;
    pt_d     = pt_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    adr_d    = adr_q;
    busy_d   = busy_q;
    o_d      = o_q;
    ferr_d   = 1'b0;
    tmo_load = 1'b0;

    case (state_q)
      // DONE lasts one cycle and otherwise behaves like IDLE: busy_o is low.
      IFILL_IDLE, IFILL_DONE: begin
        state_d = IFILL_IDLE;
        if (flush_i) begin
          // Flush beats a simultaneous miss; the miss is dropped.
          o_d.v = 1'b0;
        end else if (miss_i) begin
          ip_d     = miss_ip_i;
          pip_d    = miss_pip_i;
          pt_d     = miss_pt_i;
          beat_d   = miss_ip_i[LINE_OFS:BEAT_OFS+1];
          bcnt_d   = '0;
          adr_d    = beat_addr(miss_ip_i[AWID:LINE_OFS+1], miss_ip_i[LINE_OFS:BEAT_OFS+1]);
          cyc_d    = 1'b1;
          stb_d    = 1'b1;
          busy_d   = 1'b1;
          o_d.v    = 1'b0;
          tmo_load = 1'b1;
          state_d  = IFILL_BEAT;
        end
      end

      IFILL_BEAT: begin
        if (err_i || tmo_expire) begin
          // A fill abandoned by flush in this same cycle reports no error.
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          busy_d  = 1'b0;
          ferr_d  = !flush_i;
          state_d = IFILL_IDLE;
        end else if (flush_i) begin
          if (ack_i) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = IFILL_IDLE;
          end else begin
            // The strobed beat must still be completed on the bus.
            state_d = IFILL_DRAIN;
          end
        end else if (ack_i) begin
          o_d.cacheline[int'(beat_q)*BEAT_BITS +: BEAT_BITS] = dat_i;
          beat_d = beat_q + BIDX_W'(1);
          bcnt_d = bcnt_q + BIDX_W'(1);
          if (bcnt_q == BIDX_W'(NBEATS - 1)) begin
            cyc_d           = 1'b0;
            stb_d           = 1'b0;
            busy_d          = 1'b0;
            o_d.v           = 1'b1;
            o_d.ip          = ip_q;
            o_d.pip         = pip_q;
            o_d.predict_taken = pt_q;
            state_d         = IFILL_DONE;
          end else begin
            // Beat index wraps modulo NBEATS, so the address stays in the line.
            adr_d = beat_addr(ip_q[AWID:LINE_OFS+1], beat_q + BIDX_W'(1));
          end
        end
      end

      // Flushed fill: finish the outstanding beat, discard it, report nothing.
      IFILL_DRAIN: begin
        if (ack_i || err_i || tmo_expire) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IFILL_IDLE;
        end
      end

      default: state_d = IFILL_IDLE;
    endcase
  end

  // State and registered outputs; reset drops the bus cycle immediately.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values computed before this edge, independent of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IFILL_IDLE;
      beat_q  <= '0;
      bcnt_q  <= '0;
      ip_q    <= '0;
      pip_q   <= '0;
      pt_q    <= 1'b0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      bcnt_q  <= bcnt_d;
      ip_q    <= ip_d;
      pip_q   <= pip_d;
      pt_q    <= pt_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      o_q     <= o_d;
    end
  end

  assign busy_o = busy_q;
  assign cyc_o  = cyc_q;
  assign stb_o  = stb_q;
  assign adr_o  = adr_q;
  assign ferr_o = ferr_q;
  assign o      = o_q;

endmodule

// File: tb/tb_any1_iline_fill.sv
// Self-checking bench for any1_iline_fill: a bus model answers beats from a
// per-fill data table; expected addresses and lines are queued at miss time.
module tb_any1_iline_fill;
  import any1_pkg::*;

  logic                 rst_i, clk_i;
  logic                 miss_i, miss_pt_i, flush_i;
  logic [AWID:0]        miss_ip_i, miss_pip_i;
  logic                 busy_o, cyc_o, stb_o, ferr_o;
  logic [AWID-1:0]      adr_o;
  logic                 ack_i, err_i;
  logic [BEAT_BITS-1:0] dat_i;
  sInstAlignIn          o;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [AWID:0]        ip;
    logic [AWID:0]        pip;
    logic                 pt;
    logic [LINE_BITS-1:0] line;
  } exp_t;

  exp_t                 exp_q[$];     // completed lines expected, in order
  logic [AWID-1:0]      adr_exp[$];   // beat addresses expected, in order
  logic [BEAT_BITS-1:0] dat_tab [NBEATS];
  exp_t                 mon_e;
  logic                 prev_v;

  any1_iline_fill #(.TMO(255)) dut (
    .rst_i      (rst_i),
    .clk_i      (clk_i),
    .miss_i     (miss_i),
    .miss_ip_i  (miss_ip_i),
    .miss_pip_i (miss_pip_i),
    .miss_pt_i  (miss_pt_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .cyc_o      (cyc_o),
    .stb_o      (stb_o),
    .adr_o      (adr_o),
    .ack_i      (ack_i),
    .err_i      (err_i),
    .dat_i      (dat_i),
    .o          (o),
    .ferr_o     (ferr_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Output monitor: every rising o.v must match the oldest queued line.
  initial begin
    prev_v = 1'b0;
    forever begin
      @(negedge clk_i);
      if (o.v === 1'b1 && prev_v !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_valid: o.v=1 ip=%h with no completed fill expected", o.ip);
        end else begin
          mon_e = exp_q.pop_front();
          if (o.cacheline !== mon_e.line || o.ip !== mon_e.ip ||
              o.pip !== mon_e.pip || o.predict_taken !== mon_e.pt)
            $display("FAIL line_out: got ip=%h pip=%h pt=%b line=%h want ip=%h pip=%h pt=%b line=%h",
                     o.ip, o.pip, o.predict_taken, o.cacheline,
                     mon_e.ip, mon_e.pip, mon_e.pt, mon_e.line);
          else passed++;
        end
      end
      prev_v = o.v;
    end
  end

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic rand_data();
    for (int s = 0; s < NBEATS; s++)
      dat_tab[s] = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Drive a one-cycle miss and queue the expected beat addresses (and the
  // expected completed line when the fill is meant to finish).
  task automatic issue_miss(input logic [AWID:0] ipv, input logic [AWID:0] pipv,
                            input logic pt, input bit expect_done);
    exp_t                 e;
    logic [AWID-1:0]      ip_byte;
    logic [1:0]           s;
    logic [LINE_BITS-1:0] line;
    ip_byte = ipv[AWID:1];
    for (int k = 0; k < NBEATS; k++) begin
      s = 2'(ip_byte[5:4] + k);
      adr_exp.push_back({ip_byte[31:6], s, 4'h0});
    end
    if (expect_done) begin
      for (int i = 0; i < NBEATS; i++) line[i*BEAT_BITS +: BEAT_BITS] = dat_tab[i];
      e.ip   = ipv;
      e.pip  = pipv;
      e.pt   = pt;
      e.line = line;
      exp_q.push_back(e);
    end
    miss_i     = 1'b1;
    miss_ip_i  = ipv;
    miss_pip_i = pipv;
    miss_pt_i  = pt;
    step();
    miss_i     = 1'b0;
  endtask

  // Bus model: hold off for gap cycles, then acknowledge one beat with the
  // data stored for the addressed slice.
  task automatic ack_beat(input int gap, input string tag);
    logic [AWID-1:0] exp_a;
    for (int g = 0; g < gap; g++) begin
      checks++;
      if (cyc_o !== 1'b1 || stb_o !== 1'b1)
        $display("FAIL %s_wait: cyc_o=%b stb_o=%b want 1 1", tag, cyc_o, stb_o);
      else passed++;
      step();
    end
    checks++;
    if (adr_exp.size() == 0) begin
      $display("FAIL %s_adr: adr_o=%h with no beat expected", tag, adr_o);
    end else begin
      exp_a = adr_exp.pop_front();
      if (adr_o !== exp_a || stb_o !== 1'b1)
        $display("FAIL %s_adr: adr_o=%h stb_o=%b want %h 1", tag, adr_o, stb_o, exp_a);
      else passed++;
    end
    ack_i = 1'b1;
    dat_i = dat_tab[adr_o[5:4]];
    step();
    ack_i = 1'b0;
    dat_i = '0;
  endtask

  task automatic do_fill(input logic [AWID:0] ipv, input logic [AWID:0] pipv,
                         input logic pt, input int gap, input string tag);
    rand_data();
    issue_miss(ipv, pipv, pt, 1'b1);
    for (int k = 0; k < NBEATS; k++) ack_beat(gap, tag);
    checks++;
    if (o.v !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL %s_done: o.v=%b busy_o=%b want 1 0", tag, o.v, busy_o);
    else passed++;
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || busy_o !== 1'b0 || ferr_o !== 1'b0)
      $display("FAIL reset_ctl: cyc=%b stb=%b busy=%b ferr=%b want 0 0 0 0", cyc_o, stb_o, busy_o, ferr_o);
    else passed++;
    checks++;
    if (adr_o !== '0) $display("FAIL reset_adr: adr_o=%h want 0", adr_o);
    else passed++;
    checks++;
    if (o !== '0) $display("FAIL reset_o: v=%b ip=%h pip=%h want all zero", o.v, o.ip, o.pip);
    else passed++;
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_aligned();
    for (int s = 0; s < NBEATS; s++) dat_tab[s] = {4{32'hDDDD_0000 + 32'(s)}};
    issue_miss({32'h1000, 1'b0}, {32'h0FF0, 1'b0}, 1'b0, 1'b1);
    checks++;
    if (cyc_o !== 1'b1 || stb_o !== 1'b1 || busy_o !== 1'b1 || o.v !== 1'b0)
      $display("FAIL aligned_start: cyc=%b stb=%b busy=%b v=%b want 1 1 1 0", cyc_o, stb_o, busy_o, o.v);
    else passed++;
    for (int k = 0; k < NBEATS - 1; k++) ack_beat(0, "aligned");
    checks++;
    if (o.v !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL aligned_cycle4: v=%b busy=%b want 0 1", o.v, busy_o);
    else passed++;
    ack_beat(0, "aligned");
    checks++;
    if (o.v !== 1'b1 || busy_o !== 1'b0 || cyc_o !== 1'b0 || stb_o !== 1'b0)
      $display("FAIL aligned_cycle5: v=%b busy=%b cyc=%b stb=%b want 1 0 0 0", o.v, busy_o, cyc_o, stb_o);
    else passed++;
    step();
    checks++;
    if (o.v !== 1'b1 || o.ip !== {32'h1000, 1'b0} || o.cacheline[127:0] !== {4{32'hDDDD_0000}})
      $display("FAIL aligned_hold: v=%b ip=%h slice0=%h want 1 %h %h", o.v, o.ip, o.cacheline[127:0],
               {32'h1000, 1'b0}, {4{32'hDDDD_0000}});
    else passed++;
  endtask

  task automatic test_wrap();
    rand_data();
    issue_miss({32'h2034, 1'b1}, {32'h2030, 1'b1}, 1'b1, 1'b1);
    checks++;
    if (o.v !== 1'b0 || adr_o !== 32'h2030)
      $display("FAIL wrap_start: v=%b adr_o=%h want 0 00002030", o.v, adr_o);
    else passed++;
    for (int k = 0; k < NBEATS; k++) ack_beat(0, "wrap");
    checks++;
    if (o.v !== 1'b1) $display("FAIL wrap_done: v=%b want 1", o.v);
    else passed++;
  endtask

  task automatic test_wait_states();
    logic [AWID-1:0] a;
    rand_data();
    issue_miss({32'h4050, 1'b0}, {32'h4040, 1'b0}, 1'b0, 1'b1);
    a          = adr_o;
    miss_i     = 1'b1;
    miss_ip_i  = {32'h9000, 1'b0};
    step();
    miss_i     = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || adr_o !== a || cyc_o !== 1'b1)
      $display("FAIL busy_miss_ignored: busy=%b adr_o=%h cyc=%b want 1 %h 1", busy_o, adr_o, cyc_o, a);
    else passed++;
    for (int k = 0; k < NBEATS; k++) ack_beat(2, "waits");
    checks++;
    if (o.v !== 1'b1) $display("FAIL waits_done: v=%b want 1", o.v);
    else passed++;
  endtask

  task automatic test_err();
    logic [AWID-1:0] exp_a;
    rand_data();
    issue_miss({32'h5000, 1'b0}, {32'h4FF0, 1'b0}, 1'b0, 1'b0);
    ack_beat(0, "err");
    ack_beat(0, "err");
    exp_a = adr_exp.pop_front();
    checks++;
    if (adr_o !== exp_a) $display("FAIL err_adr: adr_o=%h want %h", adr_o, exp_a);
    else passed++;
    err_i = 1'b1;
    ack_i = 1'b1;   // err wins over a simultaneous ack
    step();
    err_i = 1'b0;
    ack_i = 1'b0;
    checks++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || busy_o !== 1'b0 || ferr_o !== 1'b1 || o.v !== 1'b0)
      $display("FAIL err_resp: cyc=%b stb=%b busy=%b ferr=%b v=%b want 0 0 0 1 0",
               cyc_o, stb_o, busy_o, ferr_o, o.v);
    else passed++;
    step();
    checks++;
    if (ferr_o !== 1'b0 || o.v !== 1'b0)
      $display("FAIL err_pulse: ferr=%b v=%b want 0 0", ferr_o, o.v);
    else passed++;
    adr_exp.delete();
  endtask

  task automatic test_timeout();
    int drop_at;
    drop_at = -1;
    issue_miss({32'h5800, 1'b0}, {32'h57F0, 1'b0}, 1'b0, 1'b0);
    for (int c = 1; c <= 300; c++) begin
      if (cyc_o !== 1'b1) begin
        drop_at = c;
        break;
      end
      step();
    end
    checks++;
    if (drop_at != 256) $display("FAIL tmo_cycle: cyc_o dropped at cycle %0d want 256", drop_at);
    else passed++;
    checks++;
    if (ferr_o !== 1'b1 || stb_o !== 1'b0 || o.v !== 1'b0)
      $display("FAIL tmo_resp: ferr=%b stb=%b v=%b want 1 0 0", ferr_o, stb_o, o.v);
    else passed++;
    step();
    checks++;
    if (ferr_o !== 1'b0) $display("FAIL tmo_pulse: ferr=%b want 0", ferr_o);
    else passed++;
    adr_exp.delete();
  endtask

  task automatic test_flush();
    rand_data();
    issue_miss({32'h3010, 1'b0}, {32'h3000, 1'b0}, 1'b1, 1'b0);
    ack_beat(0, "flush");
    ack_beat(0, "flush");
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if (cyc_o !== 1'b1 || stb_o !== 1'b1 || busy_o !== 1'b1)
        $display("FAIL flush_drain_hold: cyc=%b stb=%b busy=%b want 1 1 1", cyc_o, stb_o, busy_o);
      else passed++;
      step();
    end
    ack_beat(0, "flush_drain");
    checks++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || busy_o !== 1'b0 || ferr_o !== 1'b0 || o.v !== 1'b0)
      $display("FAIL flush_end: cyc=%b stb=%b busy=%b ferr=%b v=%b want 0 0 0 0 0",
               cyc_o, stb_o, busy_o, ferr_o, o.v);
    else passed++;
    step();
    checks++;
    if (ferr_o !== 1'b0 || o.v !== 1'b0 || cyc_o !== 1'b0)
      $display("FAIL flush_quiet: ferr=%b v=%b cyc=%b want 0 0 0", ferr_o, o.v, cyc_o);
    else passed++;
    adr_exp.delete();
    do_fill({32'h3010, 1'b1}, {32'h3000, 1'b0}, 1'b1, 0, "after_flush");
  endtask

  task automatic test_flush_with_miss();
    // o.v is high from the preceding fill.
    flush_i   = 1'b1;
    miss_i    = 1'b1;
    miss_ip_i = {32'h7000, 1'b0};
    step();
    flush_i   = 1'b0;
    miss_i    = 1'b0;
    checks++;
    if (o.v !== 1'b0 || busy_o !== 1'b0 || cyc_o !== 1'b0)
      $display("FAIL flush_beats_miss: v=%b busy=%b cyc=%b want 0 0 0", o.v, busy_o, cyc_o);
    else passed++;
  endtask

  task automatic test_reset_mid();
    rand_data();
    issue_miss({32'h6020, 1'b0}, {32'h6010, 1'b0}, 1'b1, 1'b0);
    ack_beat(0, "rst_mid");
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || busy_o !== 1'b0 || o.v !== 1'b0 || adr_o !== '0)
      $display("FAIL rst_async: cyc=%b stb=%b busy=%b v=%b adr=%h want 0 0 0 0 0",
               cyc_o, stb_o, busy_o, o.v, adr_o);
    else passed++;
    step();
    rst_i = 1'b0;
    adr_exp.delete();
    step();
    do_fill({32'h6020, 1'b1}, {32'h6010, 1'b1}, 1'b1, 1, "after_rst");
  endtask

  initial begin
    rst_i      = 1'b1;
    miss_i     = 1'b0;
    miss_ip_i  = '0;
    miss_pip_i = '0;
    miss_pt_i  = 1'b0;
    flush_i    = 1'b0;
    ack_i      = 1'b0;
    err_i      = 1'b0;
    dat_i      = '0;

    test_reset();
    test_aligned();
    test_wrap();
    test_wait_states();
    test_err();
    test_timeout();
    test_flush();
    test_flush_with_miss();
    test_reset_mid();
    step();

    checks++;
    if (exp_q.size() != 0 || adr_exp.size() != 0)
      $display("FAIL leftovers: lines=%0d beats=%0d still expected want 0 0", exp_q.size(), adr_exp.size());
    else passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
